// File: rtl/core_s_pkg.sv
// Shared core_s types. The DIV writeback entry pairs a result with its
// destination register tag.
package core_s_pkg;

  localparam int DIV_WB_XLEN  = 32;
  localparam int DIV_WB_TAGW  = 5;
  localparam int DIV_WB_DEPTH = 2;

  typedef struct packed {
    logic [DIV_WB_TAGW-1:0] rd;
    logic [DIV_WB_XLEN-1:0] data;
  } div_wb_entry_t;

endpackage

// File: rtl/div_result_buffer.sv
// In-order FIFO between the DIV unit and the writeback arbiter, with flush and
// silent drop of results that target x0.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high; valid never waits for ready, and ready depends on registered state only.
module div_result_buffer
  import core_s_pkg::*;
#(
  parameter int XLEN  = DIV_WB_XLEN,
  parameter int TAGW  = DIV_WB_TAGW,
  parameter int DEPTH = DIV_WB_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [TAGW-1:0]          in_rd,
  input  logic [XLEN-1:0]          in_result,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [TAGW-1:0]          out_rd,
  output logic [XLEN-1:0]          out_result,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  div_wb_entry_t   mem [DEPTH];
  div_wb_entry_t   head;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            empty;
  logic            full;
  logic            push;
  logic            pop;

  // The extra MSB distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[PW-1] != rd_ptr[PW-1]);

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready && !flush && (in_rd != '0);
  assign pop       = out_valid && out_ready && !flush;
  assign count     = wr_ptr - rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (flush)    rd_ptr <= wr_ptr;
      else if (pop) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage carries no reset; it is only observable while out_valid is high.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]].rd   <= in_rd;
      mem[wr_ptr[AW-1:0]].data <= in_result;
    end
  end

  assign head       = mem[rd_ptr[AW-1:0]];
  assign out_rd     = head.rd;
  assign out_result = head.data;

  a_no_push_full : assert property (@(posedge clk) disable iff (rst) !(push && full));
  a_count_bound  : assert property (@(posedge clk) disable iff (rst) count <= DEPTH);

endmodule

// File: tb/tb_div_result_buffer.sv
// Self-checking bench for div_result_buffer: a queue model tracks accepted
// entries and every negedge compares outputs against it.
module tb_div_result_buffer;

  localparam int XLEN  = 32;
  localparam int TAGW  = 5;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [TAGW-1:0] in_rd;
  logic [XLEN-1:0] in_result;
  logic            out_valid;
  logic            out_ready;
  logic [TAGW-1:0] out_rd;
  logic [XLEN-1:0] out_result;
  logic [CW-1:0]   count;

  logic [TAGW+XLEN-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int n_pop = 0;

  div_result_buffer #(.XLEN(XLEN), .TAGW(TAGW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_result(in_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
    .out_result(out_result), .count(count)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard: check state reached so far, then apply this cycle's ops
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      check("rst_count", 64'(count), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
    end else begin
      check("count", 64'(count), 64'(exp_q.size()));
      check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      check("in_ready", 64'(in_ready), 64'(exp_q.size() < DEPTH));
      if (out_valid && exp_q.size() != 0) begin
        check("out_rd", 64'(out_rd), 64'(exp_q[0][TAGW+XLEN-1:XLEN]));
        check("out_result", 64'(out_result), 64'(exp_q[0][XLEN-1:0]));
      end
      if (flush) begin
        exp_q.delete();
      end else begin
        if (out_valid && out_ready && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          n_pop++;
        end
        if (in_valid && (exp_q.size() < DEPTH || (out_valid && out_ready && 0)) &&
            in_ready && in_rd != '0)
          exp_q.push_back({in_rd, in_result});
      end
    end
  end

  // driver: apply one cycle of inputs, then advance to just after the edge
  task automatic drive(input logic v, input logic [TAGW-1:0] rd, input logic [XLEN-1:0] d,
                       input logic ordy, input logic fl);
    in_valid  = v;
    in_rd     = rd;
    in_result = d;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, '0, '0, ordy, 1'b0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_rd = '0; in_result = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // single pass
    drive(1'b1, 5'd3, 32'h0000_0007, 1'b1, 1'b0);
    check("single_vis_valid", 64'(out_valid), 64'd1);
    check("single_vis_rd", 64'(out_rd), 64'd3);
    check("single_vis_res", 64'(out_result), 64'h7);
    idle(1'b1);
    check("single_drained", 64'(count), 64'd0);

    // fill and backpressure
    drive(1'b1, 5'd1, 32'hAAAA_0001, 1'b0, 1'b0);
    drive(1'b1, 5'd2, 32'hBBBB_0002, 1'b0, 1'b0);
    drive(1'b1, 5'd9, 32'hDEAD_0009, 1'b0, 1'b0);
    check("full_count", 64'(count), 64'd2);
    check("full_in_ready", 64'(in_ready), 64'd0);
    repeat (3) idle(1'b0);
    check("hold_rd", 64'(out_rd), 64'd1);
    check("hold_res", 64'(out_result), 64'hAAAA_0001);
    idle(1'b1);
    check("drain1_rd", 64'(out_rd), 64'd2);
    idle(1'b1);
    check("drain_empty", 64'(out_valid), 64'd0);

    // simultaneous push and pop at count=1, pointers wrap
    drive(1'b1, 5'd10, 32'h1000_0000, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 5'(11 + i), 32'h2000_0000 + 32'(i), 1'b1, 1'b0);
      check("pp_count", 64'(count), 64'd1);
    end
    idle(1'b1);

    // drop x0
    drive(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    check("x0_count", 64'(count), 64'd0);
    check("x0_out_valid", 64'(out_valid), 64'd0);

    // flush with a concurrent push
    drive(1'b1, 5'd6, 32'h6666_0006, 1'b0, 1'b0);
    drive(1'b1, 5'd7, 32'h7777_0007, 1'b0, 1'b0);
    drive(1'b1, 5'd5, 32'h5555_0005, 1'b1, 1'b1);
    check("flush_count", 64'(count), 64'd0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    repeat (2) idle(1'b1);
    check("flush_no_rd5", 64'(out_valid), 64'd0);

    // reset mid-stream with two buffered entries
    drive(1'b1, 5'd12, 32'hC000_000C, 1'b0, 1'b0);
    drive(1'b1, 5'd13, 32'hD000_000D, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_count", 64'(count), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(1'b0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom,
            $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
    end
    repeat (3) idle(1'b1);
    check("final_empty", 64'(count), 64'd0);
    check("pops_seen", 64'(n_pop > 20), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/div_result_buffer.md
Name: div_result_buffer

Overview:
- Downstream stage of the single-cycle DIV unit in core_s.
- Captures each DIV result with its destination-register tag in a small in-order FIFO, then drains it to the writeback arbiter over a valid/ready handshake.
- Decouples DIV's always-ready output from writeback-port contention and supports pipeline flush.

Parameters:
XLEN, 32, datapath width of the result.
TAGW, 5, destination register index width.
DEPTH, 2, number of FIFO entries; power of two, at least 2.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset, asynchronous, active-high.
flush  input  1  discard all buffered entries (pipeline redirect).
in_valid  input  1  DIV out_valid qualified by the issuing instruction.
in_ready  output  1  buffer can accept an entry this cycle.
in_rd  input  TAGW  destination register index of the incoming result.
in_result  input  XLEN  DIV result (quotient or remainder).
out_valid  output  1  head entry is valid.
out_ready  input  1  writeback accepts the head entry.
out_rd  output  TAGW  head entry destination index.
out_result  output  XLEN  head entry result.
count  output  $clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (rst=1, asynchronous): wr_ptr=0, rd_ptr=0, count=0, out_valid=0, in_ready=1. Entry storage is not reset. out_rd and out_result read the head entry and are don't-care while out_valid=0.
- Pointers are $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = index bits equal and wrap bits differ.
- in_ready = !full. It depends on registered state only, with no combinational path from out_ready.
- push = in_valid & in_ready & !flush & (in_rd != 0).
  - Results targeting x0 are accepted and silently dropped: handshake completes, no entry is written.
- pop = out_valid & out_ready & !flush.
- out_valid = !empty. out_rd and out_result come directly from storage[rd_ptr].
- Latency: a pushed entry is visible at the output the cycle after the push edge. There is no same-cycle bypass.
- Hold rule: while out_valid=1 and out_ready=0, out_rd and out_result stay stable until popped or flushed.
- Simultaneous push and pop:
  - Allowed whenever not full. Both pointers advance and count is unchanged.
  - When full, in_ready=0, so a push cannot occur even if a pop happens in the same cycle.
- Count:
  - count += push - pop, always within 0..DEPTH.
  - Also exported as count = wr_ptr - rd_ptr.
- Flush: on the next edge, rd_ptr := wr_ptr, so count=0 and out_valid=0 the following cycle. Any push or pop presented in the flush cycle is ignored.
- Wrap-around: pointer increments roll over modulo 2*DEPTH with no special case.
- Reset asserted mid-operation discards all entries immediately; outputs return to their reset values asynchronously.
- Assertions (verification only): no push when full; count never exceeds DEPTH.

Decomposition:
- Shared package core_s_pkg gains:
  - typedef div_wb_entry_t, a packed struct {logic [TAGW-1:0] rd; logic [XLEN-1:0] data;}.
  - localparam DIV_WB_DEPTH=2.
- Single module; no sub-module. Storage is an array of div_wb_entry_t.

Test Plan:
- Reset: hold rst=1 mid-stream with 2 entries buffered, then release → out_valid=0, in_ready=1, count=0.
- Single pass: push rd=3, result=0x00000007 with out_ready=1 → next cycle out_valid=1, out_rd=3, out_result=0x7; popped that cycle; the cycle after, count=0.
- Fill and backpressure: out_ready=0, push rd=1/0xAAAA0001 then rd=2/0xBBBB0002 → count=2, in_ready=0, output holds rd=1/0xAAAA0001. Then out_ready=1 → entries drain in order over 2 cycles.
- Simultaneous push and pop at count=1, run continuously for 10 cycles with pointers wrapping → count stays 1 and output order matches input order.
- Drop x0: push rd=0, result=0xFFFFFFFF → in_ready handshake completes, count stays 0, out_valid stays 0.
- Flush: 2 entries buffered, flush=1 together with in_valid=1 (rd=5) → next cycle count=0 and out_valid=0; rd=5 never appears at the output.
